// File: rtl/afe_ctrl.sv
// ============================================================================
// afe_ctrl : SPI register slave with per-channel hit latches and counters
// Rev 1.0
// ============================================================================
`default_nettype none

module afe_ctrl #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RST_B,
    input  logic              SCLK,
    input  logic              CS_B,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [N_CH-1:0]   COMP,
    input  logic              INJ_IN,
    output logic              INJ_OUT,
    output logic [N_CH-1:0]   HIT,
    output logic [GPIO_W-1:0] GPIO,
    output logic              LED
);

    localparam int              IN_W    = N_CH + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Synchroniser chain: meta -> sync, plus prev for edge detection
    logic [IN_W-1:0] meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;

    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        sout_q, sout_d;
    logic              rw_q, rw_d;
    logic [6:0]        addr_q, addr_d;
    logic              miso_q, miso_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic [N_CH-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, inj_s;
    logic [N_CH-1:0]   comp_s, comp_p, comp_rise, qual;
    logic              commit, clr;
    logic [6:0]        rd_addr;
    logic [7:0]        rdata;
    logic [N_CH-1:0]   en_wr;

    always_comb begin
        meta_d = {INJ_IN, COMP, MOSI, CS_B, SCLK};
        sync_d = meta_q;
        prev_d = sync_q;
    end

    assign sclk_rise = sync_q[0] & ~prev_q[0];
    assign sclk_fall = ~sync_q[0] & prev_q[0];
    assign cs_rise   = sync_q[1] & ~prev_q[1];
    assign cs_fall   = ~sync_q[1] & prev_q[1];
    assign mosi_s    = sync_q[2];
    assign comp_s    = sync_q[N_CH+2:3];
    assign comp_p    = prev_q[N_CH+2:3];
    assign inj_s     = sync_q[N_CH+3];
    assign comp_rise = comp_s & ~comp_p;

    // Address as it completes on the 8th ADDR-phase rising edge
    assign rd_addr = {shift_q[5:0], mosi_s};

    always_comb begin
        rdata = 8'h00;
        case (rd_addr)
            7'h00:   rdata = 8'(gpio_q);
            7'h01:   rdata = 8'(en_q);
            7'h02:   rdata = 8'(hit_q);
            default: rdata = 8'h00;
        endcase
        for (int c = 0; c < N_CH; c++) begin
            if (rd_addr == 7'(16 + c)) begin
                rdata = 8'(cnt_q[c]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        sout_d   = sout_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        miso_d   = miso_q;
        commit   = 1'b0;
        if (cs_rise) begin
            commit  = (state_q == ST_DONE) && !rw_q;
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d  = ST_ADDR;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_ADDR: begin
                    miso_d = 1'b0;
                    if (sclk_rise) begin
                        shift_d  = {shift_q[6:0], mosi_s};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rw_d    = shift_q[6];
                            addr_d  = rd_addr;
                            sout_d  = shift_q[6] ? rdata : 8'h00;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        miso_d = sout_q[7];
                        sout_d = {sout_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d  = {shift_q[6:0], mosi_s};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    // EN is an 8-bit register; channels above 7 keep their enable
    generate
        if (N_CH <= 8) begin : g_en_narrow
            assign en_wr = shift_q[N_CH-1:0];
        end else begin : g_en_wide
            assign en_wr = {en_q[N_CH-1:8], shift_q};
        end
    endgenerate

    always_comb begin
        gpio_d = gpio_q;
        en_d   = en_q;
        clr    = 1'b0;
        if (commit) begin
            case (addr_q)
                7'h00:   gpio_d = shift_q[GPIO_W-1:0];
                7'h01:   en_d   = en_wr;
                7'h03:   clr    = shift_q[0];
                default: clr    = 1'b0;
            endcase
        end
    end

    assign qual  = comp_rise & en_q & {N_CH{inj_s}};
    assign hit_d = inj_s ? (hit_q | qual) : '0;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clr) begin
                cnt_d[c] = '0;
            end else if (qual[c] && (cnt_q[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            sout_q   <= 8'h00;
            rw_q     <= 1'b0;
            addr_q   <= 7'h00;
            miso_q   <= 1'b0;
            gpio_q   <= '0;
            en_q     <= '1;
            hit_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            sout_q   <= sout_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            miso_q   <= miso_d;
            gpio_q   <= gpio_d;
            en_q     <= en_d;
            hit_q    <= hit_d;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign MISO    = miso_q & ~CS_B;
    assign INJ_OUT = INJ_IN;
    assign HIT     = hit_q;
    assign GPIO    = gpio_q;
    assign LED     = |hit_q;

endmodule

`default_nettype wire

// File: tb/tb_afe_ctrl.sv
// ============================================================================
// tb_afe_ctrl : directed vector bench for afe_ctrl (N_CH=4, CNT_W=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_afe_ctrl;

    localparam int N_CH = 4;
    localparam int OP_WR = 0, OP_RD = 1, OP_PULSE = 2, OP_INJ = 3;

    logic            CLK = 1'b0;
    logic            RST_B, SCLK, CS_B, MOSI, INJ_IN;
    logic [N_CH-1:0] COMP;
    logic            MISO, INJ_OUT, LED;
    logic [N_CH-1:0] HIT;
    logic [7:0]      GPIO;

    int n_vec = 0;
    int n_err = 0;

    afe_ctrl #(.N_CH(N_CH), .CNT_W(4), .GPIO_W(8)) dut (
        .CLK(CLK), .RST_B(RST_B), .SCLK(SCLK), .CS_B(CS_B), .MOSI(MOSI),
        .MISO(MISO), .COMP(COMP), .INJ_IN(INJ_IN), .INJ_OUT(INJ_OUT),
        .HIT(HIT), .GPIO(GPIO), .LED(LED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         op;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        int         ch;
        int         cnt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int op, logic [6:0] a, logic [7:0] d, int nb,
                                int ch, int cnt, logic [7:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.nbits = nb;
        v.ch = ch; v.cnt = cnt; v.exp = e;
        return v;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        CS_B = 1'b0;
        clks(8);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? frame[15-i] : 1'b0;
            clks(8);
            if (i >= 8 && i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            clks(8);
            SCLK = 1'b0;
        end
        clks(8);
        CS_B = 1'b1;
        MOSI = 1'b0;
        clks(8);
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            COMP[ch] = 1'b1;
            clks(4);
            COMP[ch] = 1'b0;
            clks(4);
        end
    endtask

    initial begin
        logic [7:0] rd;
        string      nm;

        RST_B = 1'b0; SCLK = 1'b0; CS_B = 1'b1; MOSI = 1'b0;
        INJ_IN = 1'b0; COMP = '0;

        vecs.push_back(mk(OP_RD,    7'h00, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h01, 8'h00, 16, 0, 0,  8'h0F));
        vecs.push_back(mk(OP_WR,    7'h00, 8'hA5, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_RD,    7'h00, 8'h00, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_WR,    7'h00, 8'h3C, 12, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_RD,    7'h00, 8'h00, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_INJ,   7'h00, 8'h01, 0,  0, 0,  8'h00));
        vecs.push_back(mk(OP_PULSE, 7'h00, 8'h00, 0,  2, 3,  8'h04));
        vecs.push_back(mk(OP_RD,    7'h12, 8'h00, 16, 0, 0,  8'h03));
        vecs.push_back(mk(OP_RD,    7'h02, 8'h00, 16, 0, 0,  8'h04));
        vecs.push_back(mk(OP_INJ,   7'h00, 8'h00, 0,  0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h12, 8'h00, 16, 0, 0,  8'h03));
        vecs.push_back(mk(OP_WR,    7'h01, 8'h0B, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_INJ,   7'h00, 8'h01, 0,  0, 0,  8'h00));
        vecs.push_back(mk(OP_PULSE, 7'h00, 8'h00, 0,  2, 1,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h12, 8'h00, 16, 0, 0,  8'h03));
        vecs.push_back(mk(OP_PULSE, 7'h00, 8'h00, 0,  0, 1,  8'h01));
        vecs.push_back(mk(OP_RD,    7'h10, 8'h00, 16, 0, 0,  8'h01));
        vecs.push_back(mk(OP_PULSE, 7'h00, 8'h00, 0,  1, 20, 8'h03));
        vecs.push_back(mk(OP_RD,    7'h11, 8'h00, 16, 0, 0,  8'h0F));
        vecs.push_back(mk(OP_WR,    7'h03, 8'h01, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_RD,    7'h11, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h10, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h02, 8'h00, 16, 0, 0,  8'h03));
        vecs.push_back(mk(OP_WR,    7'h02, 8'hFF, 16, 0, 0,  8'hA5));
        vecs.push_back(mk(OP_RD,    7'h02, 8'h00, 16, 0, 0,  8'h03));
        vecs.push_back(mk(OP_RD,    7'h03, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h20, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_RD,    7'h14, 8'h00, 16, 0, 0,  8'h00));
        vecs.push_back(mk(OP_WR,    7'h00, 8'h66, 18, 0, 0,  8'h66));
        vecs.push_back(mk(OP_WR,    7'h00, 8'h5A, 16, 0, 0,  8'h5A));
        vecs.push_back(mk(OP_RD,    7'h01, 8'h00, 16, 0, 0,  8'h0B));

        clks(5);
        chk("reset_gpio", GPIO, 8'h00);
        chk("reset_hit", {4'h0, HIT}, 8'h00);
        chk("reset_miso", {7'h0, MISO}, 8'h00);
        chk("reset_led", {7'h0, LED}, 8'h00);
        RST_B = 1'b1;
        clks(8);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: begin
                    spi_frame({1'b0, vecs[i].addr, vecs[i].data}, vecs[i].nbits, rd);
                    clks(4);
                    nm = $sformatf("vec%0d_wr_gpio", i);
                    chk(nm, GPIO, vecs[i].exp);
                end
                OP_RD: begin
                    spi_frame({1'b1, vecs[i].addr, 8'h00}, 16, rd);
                    nm = $sformatf("vec%0d_rd_%02h", i, vecs[i].addr);
                    chk(nm, rd, vecs[i].exp);
                    nm = $sformatf("vec%0d_miso_idle", i);
                    chk(nm, {7'h0, MISO}, 8'h00);
                end
                OP_PULSE: begin
                    pulse(vecs[i].ch, vecs[i].cnt);
                    clks(4);
                    nm = $sformatf("vec%0d_hit", i);
                    chk(nm, {4'h0, HIT}, vecs[i].exp);
                    nm = $sformatf("vec%0d_led", i);
                    chk(nm, {7'h0, LED}, {7'h0, |vecs[i].exp});
                end
                default: begin
                    INJ_IN = vecs[i].data[0];
                    clks(5);
                    nm = $sformatf("vec%0d_inj_hit", i);
                    chk(nm, {4'h0, HIT}, vecs[i].exp);
                    nm = $sformatf("vec%0d_inj_out", i);
                    chk(nm, {7'h0, INJ_OUT}, {7'h0, vecs[i].data[0]});
                end
            endcase
        end

        // HIT latency: invisible after 2 edges, set after the 3rd
        COMP[3] = 1'b1;
        clks(2);
        chk("lat_2clk", {4'h0, HIT}, 8'h03);
        clks(1);
        chk("lat_3clk", {4'h0, HIT}, 8'h0B);
        COMP[3] = 1'b0;
        clks(6);

        // Edge arriving together with INJ_IN low: latches clear, no count
        COMP[0] = 1'b1;
        INJ_IN  = 1'b0;
        clks(5);
        chk("simul_hit", {4'h0, HIT}, 8'h00);
        COMP[0] = 1'b0;
        clks(4);
        spi_frame(16'h9000, 16, rd);
        chk("simul_cnt0", rd, 8'h00);
        INJ_IN = 1'b1;
        clks(4);
        pulse(1, 2);
        clks(4);
        chk("pre_rst_hit", {4'h0, HIT}, 8'h02);

        // Reset mid-read and mid-hit
        CS_B = 1'b0;
        clks(8);
        for (int i = 0; i < 5; i++) begin
            MOSI = (i == 0);
            clks(8);
            SCLK = 1'b1;
            clks(8);
            SCLK = 1'b0;
        end
        COMP[1] = 1'b1;
        clks(1);
        RST_B = 1'b0;
        #1;
        chk("rst_gpio", GPIO, 8'h00);
        chk("rst_hit", {4'h0, HIT}, 8'h00);
        chk("rst_led", {7'h0, LED}, 8'h00);
        clks(3);
        CS_B = 1'b1; COMP = '0; MOSI = 1'b0;
        RST_B = 1'b1;
        clks(8);
        spi_frame(16'h8100, 16, rd);
        chk("post_rst_en", rd, 8'h0F);
        spi_frame(16'h8000, 16, rd);
        chk("post_rst_gpio", rd, 8'h00);
        spi_frame(16'h9100, 16, rd);
        chk("post_rst_cnt1", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
